// File: rtl/fp_pkg.sv
// ----------------------------------------------------------------------------
// fp_pkg : shared command codes, responses and encodings for the front-panel
//          command sequencer.                                    Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fp_pkg;

  localparam logic [7:0] CMD_NOP            = 8'h00;
  localparam logic [7:0] CMD_WRITE_LED      = 8'h01;
  localparam logic [7:0] CMD_WRITE_BRIGHT   = 8'h02;
  localparam logic [7:0] CMD_WRITE_MASK     = 8'h03;
  localparam logic [7:0] CMD_WRITE_ALL      = 8'h04;
  localparam logic [7:0] CMD_READ_CHIP_ID   = 8'h06;
  localparam logic [7:0] CMD_READ_VENDOR_ID = 8'h19;
  localparam logic [7:0] CMD_READ_INPUT     = 8'h1F;
  localparam logic [7:0] CMD_READ_STATUS    = 8'h20;
  localparam logic [7:0] CMD_CLEAR_ERR      = 8'h21;

  localparam logic [7:0] ACK        = 8'h01;
  localparam logic [7:0] NAK        = 8'h80;
  localparam logic [7:0] CHIP_ID    = 8'h71;
  localparam logic [7:0] VENDOR_ID  = 8'hAE;
  localparam logic [7:0] BRIGHT_RST = 8'hFF;

  localparam int MAX_PAYLOAD = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  localparam logic [2:0] TGT_NONE   = 3'd0;
  localparam logic [2:0] TGT_LED    = 3'd1;
  localparam logic [2:0] TGT_BRIGHT = 3'd2;
  localparam logic [2:0] TGT_MASK   = 3'd3;
  localparam logic [2:0] TGT_ALL    = 3'd4;

  localparam logic [1:0] RSP_CONST  = 2'd0;
  localparam logic [1:0] RSP_INPUT  = 2'd1;
  localparam logic [1:0] RSP_STATUS = 2'd2;

endpackage

`default_nettype wire

// File: rtl/fp_cmd_decode.sv
// ----------------------------------------------------------------------------
// fp_cmd_decode : combinational command decoder (length, response, target).
//                                                                 Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fp_cmd_decode
  import fp_pkg::*;
(
  input  logic [7:0] cmd,
  output logic [1:0] len,
  output logic [7:0] resp,
  output logic [1:0] resp_sel,
  output logic       legal,
  output logic [2:0] target,
  output logic       clr_err
);

  always_comb begin
    len      = 2'd0;
    resp     = ACK;
    resp_sel = RSP_CONST;
    legal    = 1'b1;
    target   = TGT_NONE;
    clr_err  = 1'b0;
    case (cmd)
      CMD_NOP:            ;
      CMD_WRITE_LED:      begin len = 2'd1; target = TGT_LED;    end
      CMD_WRITE_BRIGHT:   begin len = 2'd1; target = TGT_BRIGHT; end
      CMD_WRITE_MASK:     begin len = 2'd1; target = TGT_MASK;   end
      CMD_WRITE_ALL:      begin len = 2'd3; target = TGT_ALL;    end
      CMD_READ_CHIP_ID:   resp     = CHIP_ID;
      CMD_READ_VENDOR_ID: resp     = VENDOR_ID;
      CMD_READ_INPUT:     resp_sel = RSP_INPUT;
      CMD_READ_STATUS:    resp_sel = RSP_STATUS;
      CMD_CLEAR_ERR:      clr_err  = 1'b1;
      default: begin
        resp  = NAK;
        legal = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fp_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// fp_cmd_sequencer : SPI frame decoder with checksummed, staged register
//                    commits and next-slot response selection.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fp_cmd_sequencer
  import fp_pkg::*;
(
  input  logic       SCLK,
  input  logic       NRST,
  input  logic       SS,
  input  logic [7:0] RX_BYTE,
  input  logic       RX_VALID,
  input  logic [7:0] INPUTPORT,
  output logic [7:0] TX_BYTE,
  output logic [7:0] LEDPORT,
  output logic [7:0] BRIGHT,
  output logic [7:0] IRQ_MASK,
  output logic       ERR,
  output logic       FRAME_OK
);

  logic [1:0] w_len;
  logic [7:0] w_const_resp;
  logic [1:0] w_resp_sel;
  logic       w_legal;
  logic [2:0] w_target;
  logic       w_clr_err;

  fp_cmd_decode u_decode (
    .cmd      (RX_BYTE),
    .len      (w_len),
    .resp     (w_const_resp),
    .resp_sel (w_resp_sel),
    .legal    (w_legal),
    .target   (w_target),
    .clr_err  (w_clr_err)
  );

  state_e                      r_state, w_state_nxt;
  logic [1:0]                  r_remaining;
  logic [1:0]                  r_idx;
  logic [MAX_PAYLOAD-1:0][7:0] r_stage;
  logic [7:0]                  r_xor;
  logic [2:0]                  r_target;
  logic                        r_last_commit_ok;
  logic                        r_last_abort;
  logic                        r_frame_open;

  logic       w_accept, w_frame_clr;
  logic       w_cmd_accept, w_data_accept, w_chk_accept;
  logic       w_chk_match, w_commit, w_abort_seen;
  logic [7:0] w_cmd_resp;

  assign w_accept    = RX_VALID & ~SS;
  assign w_frame_clr = NRST | SS;
  assign w_chk_match = (r_xor == RX_BYTE);
  assign w_commit    = w_chk_accept & w_chk_match;
  // A frame still open while back in IDLE can only mean SS cut it short.
  assign w_abort_seen = r_last_abort | r_frame_open;

  always_ff @(posedge SCLK or posedge w_frame_clr) begin
    if (w_frame_clr) r_state <= ST_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cmd_accept  = 1'b0;
    w_data_accept = 1'b0;
    w_chk_accept  = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept) begin
        w_cmd_accept = 1'b1;
        if (w_len != 2'd0) w_state_nxt = ST_DATA;
      end
      ST_DATA: if (w_accept) begin
        w_data_accept = 1'b1;
        if (r_remaining == 2'd1) w_state_nxt = ST_CHECK;
      end
      ST_CHECK: if (w_accept) begin
        w_chk_accept = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cmd_resp = w_const_resp;
    case (w_resp_sel)
      RSP_INPUT:  w_cmd_resp = INPUTPORT;
      RSP_STATUS: w_cmd_resp = {ERR, 5'b0, r_last_commit_ok, w_abort_seen};
      default:    w_cmd_resp = w_const_resp;
    endcase
  end

  always_ff @(posedge SCLK or posedge w_frame_clr) begin
    if (w_frame_clr) begin
      r_remaining <= 2'd0;
      r_idx       <= 2'd0;
      r_stage     <= '0;
      r_xor       <= 8'h00;
      r_target    <= TGT_NONE;
    end else if (w_cmd_accept) begin
      r_remaining <= w_len;
      r_idx       <= 2'd0;
      r_xor       <= RX_BYTE;
      r_target    <= w_target;
    end else if (w_data_accept) begin
      r_stage[r_idx] <= RX_BYTE;
      r_idx          <= r_idx + 2'd1;
      r_remaining    <= r_remaining - 2'd1;
      r_xor          <= r_xor ^ RX_BYTE;
    end
  end

  always_ff @(posedge SCLK or posedge NRST) begin
    if (NRST) begin
      TX_BYTE          <= 8'h00;
      LEDPORT          <= 8'h00;
      BRIGHT           <= BRIGHT_RST;
      IRQ_MASK         <= 8'h00;
      ERR              <= 1'b0;
      FRAME_OK         <= 1'b0;
      r_last_commit_ok <= 1'b0;
      r_last_abort     <= 1'b0;
      r_frame_open     <= 1'b0;
    end else begin
      FRAME_OK <= w_commit;
      if (SS && r_frame_open) begin
        r_last_abort <= 1'b1;
        r_frame_open <= 1'b0;
      end
      if (w_cmd_accept) begin
        TX_BYTE      <= w_cmd_resp;
        r_last_abort <= 1'b0;
        r_frame_open <= (w_len != 2'd0);
        if (!w_legal)       ERR <= 1'b1;
        else if (w_clr_err) ERR <= 1'b0;
      end
      if (w_data_accept) TX_BYTE <= 8'h00;
      if (w_chk_accept) begin
        r_frame_open     <= 1'b0;
        r_last_commit_ok <= w_chk_match;
        if (w_chk_match) begin
          TX_BYTE <= ACK;
          case (r_target)
            TGT_LED:    LEDPORT  <= r_stage[0];
            TGT_BRIGHT: BRIGHT   <= r_stage[0];
            TGT_MASK:   IRQ_MASK <= r_stage[0];
            TGT_ALL: begin
              LEDPORT  <= r_stage[0];
              BRIGHT   <= r_stage[1];
              IRQ_MASK <= r_stage[2];
            end
            default: ;
          endcase
        end else begin
          TX_BYTE <= NAK;
          ERR     <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fp_cmd_sequencer : scoreboard bench with a frame-level reference model.
//                                                                 Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fp_cmd_sequencer;

  logic       SCLK = 1'b0;
  logic       NRST;
  logic       SS;
  logic [7:0] RX_BYTE;
  logic       RX_VALID;
  logic [7:0] INPUTPORT;
  logic [7:0] TX_BYTE, LEDPORT, BRIGHT, IRQ_MASK;
  logic       ERR, FRAME_OK;

  fp_cmd_sequencer dut (
    .SCLK      (SCLK),
    .NRST      (NRST),
    .SS        (SS),
    .RX_BYTE   (RX_BYTE),
    .RX_VALID  (RX_VALID),
    .INPUTPORT (INPUTPORT),
    .TX_BYTE   (TX_BYTE),
    .LEDPORT   (LEDPORT),
    .BRIGHT    (BRIGHT),
    .IRQ_MASK  (IRQ_MASK),
    .ERR       (ERR),
    .FRAME_OK  (FRAME_OK)
  );

  always #5 SCLK = ~SCLK;

  typedef struct {
    logic [7:0] tx, led, bright, mask;
    logic       err, fok;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  logic [7:0] m_led, m_bright, m_mask;
  logic       m_err, m_ok, m_abort;
  logic [7:0] mf[$];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic int cmd_len(input logic [7:0] c);
    case (c)
      8'h01, 8'h02, 8'h03: return 1;
      8'h04:               return 3;
      default:             return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_led = 8'h00; m_bright = 8'hFF; m_mask = 8'h00;
    m_err = 1'b0;  m_ok = 1'b0;      m_abort = 1'b0;
    mf.delete();
  endtask

  // Frame-level model: the pending frame is just a byte queue.
  task automatic model_byte(input logic [7:0] b, input logic [7:0] inp);
    exp_t       e;
    logic [7:0] x;
    e.fok = 1'b0;
    if (mf.size() == 0) begin
      case (b)
        8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h21: e.tx = 8'h01;
        8'h06:   e.tx = 8'h71;
        8'h19:   e.tx = 8'hAE;
        8'h1F:   e.tx = inp;
        8'h20:   e.tx = {m_err, 5'b0, m_ok, m_abort};
        default: begin e.tx = 8'h80; m_err = 1'b1; end
      endcase
      if (b == 8'h21) m_err = 1'b0;
      m_abort = 1'b0;
      if (cmd_len(b) > 0) mf.push_back(b);
    end else if (mf.size() < cmd_len(mf[0]) + 1) begin
      mf.push_back(b);
      e.tx = 8'h00;
    end else begin
      x = 8'h00;
      foreach (mf[i]) x = x ^ mf[i];
      if (x == b) begin
        case (mf[0])
          8'h01: m_led    = mf[1];
          8'h02: m_bright = mf[1];
          8'h03: m_mask   = mf[1];
          default: begin m_led = mf[1]; m_bright = mf[2]; m_mask = mf[3]; end
        endcase
        e.tx = 8'h01; e.fok = 1'b1; m_ok = 1'b1;
      end else begin
        e.tx = 8'h80; m_err = 1'b1; m_ok = 1'b0;
      end
      mf.delete();
    end
    e.led = m_led; e.bright = m_bright; e.mask = m_mask; e.err = m_err;
    sb.push_back(e);
  endtask

  // Monitor: every byte the DUT accepts yields one scoreboard entry.
  always @(posedge SCLK) begin
    if (RX_VALID && !SS && !NRST) begin
      #1;
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard_underflow: got byte response, expected none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("tx_byte",  TX_BYTE,        e.tx);
        chk("ledport",  LEDPORT,        e.led);
        chk("bright",   BRIGHT,         e.bright);
        chk("irq_mask", IRQ_MASK,       e.mask);
        chk("err",      {7'b0, ERR},    {7'b0, e.err});
        chk("frame_ok", {7'b0, FRAME_OK}, {7'b0, e.fok});
      end
    end else if (!NRST) begin
      #1;
      chk("frame_ok_idle", {7'b0, FRAME_OK}, 8'h00);
    end
  end

  task automatic send_inp(input logic [7:0] b, input logic [7:0] inp);
    RX_BYTE   = b;
    INPUTPORT = inp;
    RX_VALID  = 1'b1;
    model_byte(b, inp);
    @(negedge SCLK);
    RX_VALID  = 1'b0;
    RX_BYTE   = 8'($urandom);
    repeat ($urandom_range(0, 2)) @(negedge SCLK);
  endtask

  task automatic send(input logic [7:0] b);
    send_inp(b, 8'($urandom));
  endtask

  task automatic do_abort();
    SS = 1'b1;
    if (mf.size() != 0) m_abort = 1'b1;
    mf.delete();
    RX_BYTE  = 8'($urandom);
    RX_VALID = $urandom_range(0, 1) == 1;
    @(negedge SCLK);
    RX_VALID = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge SCLK);
    SS = 1'b0;
    @(negedge SCLK);
  endtask

  task automatic check_reset();
    chk("rst_tx",     TX_BYTE,  8'h00);
    chk("rst_led",    LEDPORT,  8'h00);
    chk("rst_bright", BRIGHT,   8'hFF);
    chk("rst_mask",   IRQ_MASK, 8'h00);
    chk("rst_err",    {7'b0, ERR},      8'h00);
    chk("rst_fok",    {7'b0, FRAME_OK}, 8'h00);
  endtask

  logic [7:0] cmds [10] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                            8'h06, 8'h19, 8'h1F, 8'h20, 8'h21};

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] fr[$];
    logic [7:0] c, x;
    int         n, abort_at;

    NRST = 1'b1; SS = 1'b1; RX_VALID = 1'b0; RX_BYTE = 8'h00; INPUTPORT = 8'h00;
    model_reset();
    repeat (3) @(negedge SCLK);
    check_reset();
    NRST = 1'b0; SS = 1'b0;
    @(negedge SCLK);

    send(8'h20);
    send(8'h06); send(8'h19); send_inp(8'h1F, 8'h5A);
    send(8'h01); send(8'h3C); send(8'h3D);
    send(8'h04); send(8'h11); send(8'h22); send(8'h33); send(8'h04);
    chk("dir_all_led",    LEDPORT,  8'h11);
    chk("dir_all_bright", BRIGHT,   8'h22);
    chk("dir_all_mask",   IRQ_MASK, 8'h33);
    send(8'h02); send(8'h10); send(8'h00);
    chk("dir_bad_bright", BRIGHT,      8'h22);
    chk("dir_bad_err",    {7'b0, ERR}, 8'h01);
    send(8'h21);
    send(8'h01); send(8'h77);
    do_abort();
    send(8'h20); send(8'h06);
    chk("dir_abort_led", LEDPORT, 8'h11);
    send(8'h55);
    send(8'h04); send(8'hAA);
    NRST = 1'b1;
    model_reset();
    repeat (2) @(negedge SCLK);
    check_reset();
    NRST = 1'b0;
    @(negedge SCLK);
    send(8'h20);

    for (int f = 0; f < 400; f++) begin
      c = ($urandom_range(0, 10) == 10) ? 8'($urandom) : cmds[$urandom_range(0, 9)];
      n = cmd_len(c);
      fr.delete();
      fr.push_back(c);
      x = c;
      for (int i = 0; i < n; i++) begin
        fr.push_back(8'($urandom));
        x = x ^ fr[i + 1];
      end
      if (n > 0) fr.push_back(($urandom_range(0, 4) == 0) ? x ^ 8'($urandom_range(1, 255)) : x);
      abort_at = (n > 0 && $urandom_range(0, 9) == 0) ? $urandom_range(1, n + 1) : 99;
      for (int i = 0; i < fr.size(); i++) begin
        if (i == abort_at) begin
          do_abort();
          break;
        end
        send(fr[i]);
      end
      if ($urandom_range(0, 29) == 0) do_abort();
    end

    repeat (3) @(negedge SCLK);
    chk("scoreboard_drained", 8'(sb.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
